rob_retire: RTL and testbench

ROB_RETIRE -- requirements
Module: rob_retire

---
 rtl/rob_retire_pkg.sv | 23 ++
 rtl/rob_retire.sv | 163 ++++++++++++++++
 tb/tb_rob_retire.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_retire_pkg.sv
// Shared widths and the reorder-buffer entry layout for the rename/retire slice.
// Also holds the FLUSH-FSM state encodings used when ROB_FLUSH_EN is defined.
package rob_retire_pkg;

  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;
  localparam int DATA_W    = 32;
  localparam int ROB_DEPTH = 16;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic              wen;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocates at tail, marks completions, retires from head.
// Define ROB_FLUSH_EN to add the flush walk (free + RAT restore, youngest first).
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [AREG_W-1:0]        alloc_rd,
  input  logic [PREG_W-1:0]        alloc_pd,
  input  logic [PREG_W-1:0]        alloc_old_pd,
  input  logic                     alloc_wen,
  output logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic                     cmpl_valid,
  input  logic [$clog2(DEPTH)-1:0] cmpl_idx,
  input  logic [DATA_W-1:0]        cmpl_data,
  output logic                     retire_valid,
  output logic [AREG_W-1:0]        retire_rd,
  output logic [PREG_W-1:0]        retire_pd,
  output logic [DATA_W-1:0]        retire_data,
  output logic                     retire_wen,
  output logic                     free_valid,
  output logic [PREG_W-1:0]        free_pd,
  output logic [$clog2(DEPTH):0]   count
`ifdef ROB_FLUSH_EN
  ,
  input  logic                     flush,
  output logic                     restore_valid,
  output logic [AREG_W-1:0]        restore_rd,
  output logic [PREG_W-1:0]        restore_pd
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  rob_entry_t       rob [DEPTH];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count_next;
  rob_entry_t       head_e;
  logic             run, do_alloc, do_retire, do_cmpl, do_walk;
  logic [IDX_W-1:0] walk_idx;

`ifdef ROB_FLUSH_EN
  logic [0:0] state;
  assign run      = (state == ST_RUN);
  assign walk_idx = tail - IDX_W'(1);
  assign do_walk  = !run && (count != '0);
`else
  assign run      = 1'b1;
  assign walk_idx = '0;
  assign do_walk  = 1'b0;
`endif

  assign head_e      = rob[head];
  assign alloc_idx   = tail;
  // Readiness looks only at the registered count: a full buffer refuses even while retiring.
  assign alloc_ready = run && (count != FULL_CNT);
  assign do_alloc    = alloc_valid && alloc_ready;
  // Decided from pre-edge state, so a head completion retires on the following edge.
  assign do_retire   = run && head_e.valid && head_e.done;
  assign do_cmpl     = run && cmpl_valid && rob[cmpl_idx].valid;

  always_comb begin
    count_next = count;
    if (do_alloc)  count_next = count_next + (IDX_W+1)'(1);
    if (do_retire) count_next = count_next - (IDX_W+1)'(1);
    if (do_walk)   count_next = count_next - (IDX_W+1)'(1);
  end

  // NOTE: only valid/done are reset; payload fields are don't-care while invalid,
  // which keeps the storage free of a wide reset network.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].done  <= 1'b0;
      end
    end else begin
      if (do_cmpl) begin
        rob[cmpl_idx].done <= 1'b1;
        rob[cmpl_idx].data <= cmpl_data;
      end
      if (do_retire) begin
        rob[head].valid <= 1'b0;
        rob[head].done  <= 1'b0;
      end
      if (do_alloc) begin
        rob[tail] <= '{valid: 1'b1, done: 1'b0, rd: alloc_rd, pd: alloc_pd,
                       old_pd: alloc_old_pd, wen: alloc_wen, data: '0};
      end
      if (do_walk) begin
        rob[walk_idx].valid <= 1'b0;
        rob[walk_idx].done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_pd    <= '0;
      retire_data  <= '0;
      retire_wen   <= 1'b0;
      free_valid   <= 1'b0;
      free_pd      <= '0;
    end else begin
      count        <= count_next;
      retire_valid <= 1'b0;
      retire_wen   <= 1'b0;
      free_valid   <= 1'b0;
      if (do_retire) begin
        retire_valid <= 1'b1;
        retire_rd    <= head_e.rd;
        retire_pd    <= head_e.pd;
        retire_data  <= head_e.data;
        retire_wen   <= head_e.wen;
        free_valid   <= head_e.wen;
        free_pd      <= head_e.old_pd;
        head         <= head + IDX_W'(1);
      end
      if (do_alloc) tail <= tail + IDX_W'(1);
`ifdef ROB_FLUSH_EN
      // Walk youngest-first: the new mapping goes back to the pool, the old one to the RAT.
      if (do_walk) begin
        tail       <= walk_idx;
        free_valid <= rob[walk_idx].wen;
        free_pd    <= rob[walk_idx].pd;
      end
`endif
    end
  end

`ifdef ROB_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      restore_valid <= 1'b0;
      restore_rd    <= '0;
      restore_pd    <= '0;
    end else begin
      restore_valid <= 1'b0;
      if (do_walk) begin
        restore_valid <= rob[walk_idx].wen;
        restore_rd    <= rob[walk_idx].rd;
        restore_pd    <= rob[walk_idx].old_pd;
      end
      case (state)
        ST_RUN:   if (flush) state <= ST_FLUSH;
        default:  if (count == '0) state <= ST_RUN;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Directed self-checking bench for rob_retire (flush steps only when ROB_FLUSH_EN is defined).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_rob_retire;
  import rob_retire_pkg::*;

  localparam int DEPTH = 16;
  localparam int IDX_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid, alloc_ready, alloc_wen;
  logic [AREG_W-1:0] alloc_rd;
  logic [PREG_W-1:0] alloc_pd, alloc_old_pd;
  logic [IDX_W-1:0]  alloc_idx, cmpl_idx;
  logic              cmpl_valid;
  logic [31:0]       cmpl_data;
  logic              retire_valid, retire_wen, free_valid;
  logic [AREG_W-1:0] retire_rd;
  logic [PREG_W-1:0] retire_pd, free_pd;
  logic [31:0]       retire_data;
  logic [IDX_W:0]    count;
`ifdef ROB_FLUSH_EN
  logic              flush, restore_valid;
  logic [AREG_W-1:0] restore_rd;
  logic [PREG_W-1:0] restore_pd;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rob_retire #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
    .alloc_pd(alloc_pd), .alloc_old_pd(alloc_old_pd), .alloc_wen(alloc_wen),
    .alloc_idx(alloc_idx),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_data(cmpl_data),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_pd(retire_pd),
    .retire_data(retire_data), .retire_wen(retire_wen),
    .free_valid(free_valid), .free_pd(free_pd), .count(count)
`ifdef ROB_FLUSH_EN
    , .flush(flush), .restore_valid(restore_valid), .restore_rd(restore_rd),
    .restore_pd(restore_pd)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [4:0] rd, input logic [5:0] pd,
                           input logic [5:0] old, input logic wen);
    alloc_valid = v; alloc_rd = rd; alloc_pd = pd; alloc_old_pd = old; alloc_wen = wen;
  endtask

  task automatic set_cmpl(input logic v, input logic [IDX_W-1:0] idx, input logic [31:0] d);
    cmpl_valid = v; cmpl_idx = idx; cmpl_data = d;
  endtask

  initial begin
    rst = 1'b1;
    set_alloc(0, 0, 0, 0, 0);
    set_cmpl(0, 0, 0);
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step();
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_count", count, 0);
    check("rst_retire_valid", retire_valid, 0);
    check("rst_free_valid", free_valid, 0);
    check("rst_alloc_idx", alloc_idx, 0);
    rst = 1'b0;

    // Basic allocate / complete / retire
    set_alloc(1, 5, 32, 5, 1);
    check("t1_alloc_idx", alloc_idx, 0);
    step();
    set_alloc(0, 0, 0, 0, 0);
    check("t1_count", count, 1);
    set_cmpl(1, 0, 32'hDEAD);
    step();
    set_cmpl(0, 0, 0);
    check("t1_no_retire_same_edge", retire_valid, 0);
    step();
    check("t1_retire_valid", retire_valid, 1);
    check("t1_retire_rd", retire_rd, 5);
    check("t1_retire_pd", retire_pd, 32);
    check("t1_retire_data", retire_data, 32'hDEAD);
    check("t1_retire_wen", retire_wen, 1);
    check("t1_free_valid", free_valid, 1);
    check("t1_free_pd", free_pd, 5);
    check("t1_count_after", count, 0);
    step();
    check("t1_retire_one_cycle", retire_valid, 0);
    check("t1_free_one_cycle", free_valid, 0);

    // wen=0 retire does not free
    set_alloc(1, 0, 10, 3, 0);
    check("t2_alloc_idx", alloc_idx, 1);
    step();
    set_alloc(0, 0, 0, 0, 0);
    set_cmpl(1, 1, 32'h1234);
    step();
    set_cmpl(0, 0, 0);
    step();
    check("t2_retire_valid", retire_valid, 1);
    check("t2_retire_wen", retire_wen, 0);
    check("t2_free_valid", free_valid, 0);
    check("t2_retire_data", retire_data, 32'h1234);
    step();

    // Out-of-order completion, in-order retire (idx 2,3,4)
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, 5'(i + 1), 6'(33 + i), 6'(11 + i), 1);
      step();
    end
    set_alloc(0, 0, 0, 0, 0);
    check("t3_count", count, 3);
    set_cmpl(1, 4, 32'h44);
    step();
    check("t3_no_retire_c4", retire_valid, 0);
    set_cmpl(1, 3, 32'h33);
    step();
    check("t3_no_retire_c3", retire_valid, 0);
    set_cmpl(1, 2, 32'h22);
    step();
    set_cmpl(0, 0, 0);
    check("t3_no_retire_c2", retire_valid, 0);
    step();
    check("t3_r0_valid", retire_valid, 1);
    check("t3_r0_rd", retire_rd, 1);
    check("t3_r0_data", retire_data, 32'h22);
    step();
    check("t3_r1_valid", retire_valid, 1);
    check("t3_r1_rd", retire_rd, 2);
    check("t3_r1_free_pd", free_pd, 12);
    step();
    check("t3_r2_valid", retire_valid, 1);
    check("t3_r2_rd", retire_rd, 3);
    check("t3_r2_data", retire_data, 32'h44);
    step();
    check("t3_idle", retire_valid, 0);
    check("t3_count_empty", count, 0);

    // Fill from idx 5, wrapping tail past 15
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1, 5'(i), 6'(16 + i), 6'(1 + i), 1);
      step();
      if (i == 10) check("t4_wrap_alloc_idx", alloc_idx, 0);
      if (i == DEPTH - 2) check("t4_ready_at_15", alloc_ready, 1);
    end
    check("t4_full_ready", alloc_ready, 0);
    check("t4_full_count", count, 16);
    set_alloc(1, 31, 63, 50, 1);
    set_cmpl(1, 5, 32'h55);
    step();
    set_cmpl(0, 0, 0);
    check("t4_full_hold_count", count, 16);
    check("t4_full_hold_ready", alloc_ready, 0);
    step();
    check("t4_retire_valid", retire_valid, 1);
    check("t4_retire_pd", retire_pd, 16);
    check("t4_free_pd", free_pd, 1);
    check("t4_count_after_retire", count, 15);
    check("t4_ready_after_retire", alloc_ready, 1);
    step();
    set_alloc(0, 0, 0, 0, 0);
    check("t4_refill_count", count, 16);
    check("t4_refill_ready", alloc_ready, 0);

    // Reset with a completed head pending: nothing retires afterwards
    set_cmpl(1, 6, 32'h66);
    step();
    set_cmpl(0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_count", count, 0);
    check("t5_rst_retire", retire_valid, 0);
    step();
    check("t5_post_retire", retire_valid, 0);
    check("t5_post_free", free_valid, 0);
    check("t5_post_idx", alloc_idx, 0);
    check("t5_post_ready", alloc_ready, 1);

`ifdef ROB_FLUSH_EN
    // Flush walks youngest to oldest
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, 5'(i + 1), 6'(40 + i), 6'(7 + i), 1);
      step();
    end
    set_alloc(0, 0, 0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("f1_ready_in_flush", alloc_ready, 0);
    for (int i = 2; i >= 0; i--) begin
      step();
      check("f1_restore_valid", restore_valid, 1);
      check("f1_restore_rd", restore_rd, i + 1);
      check("f1_restore_pd", restore_pd, 7 + i);
      check("f1_free_valid", free_valid, 1);
      check("f1_free_pd", free_pd, 40 + i);
    end
    check("f1_count_zero", count, 0);
    step();
    check("f1_restore_done", restore_valid, 0);
    check("f1_free_done", free_valid, 0);
    check("f1_back_to_run", alloc_ready, 1);

    // Reset in the middle of a flush
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, 5'(i + 1), 6'(40 + i), 6'(7 + i), 1);
      step();
    end
    set_alloc(0, 0, 0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("f2_first_pulse", restore_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("f2_rst_count", count, 0);
    check("f2_rst_restore", restore_valid, 0);
    check("f2_rst_free", free_valid, 0);
    step();
    check("f2_post_restore", restore_valid, 0);
    check("f2_post_free", free_valid, 0);
    check("f2_post_ready", alloc_ready, 1);
    check("f2_post_count", count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
